// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath widths, ALU opcodes, EX control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   XLEN, REG_ADDR_W, ALU_OP_W  datapath, register index and ALU opcode widths
//   xlen_t, reg_addr_t, alu_op_t
//   ALU_*                       opcodes shared with the ALU
//   ZERO_REG                    x0, hard-wired zero, never a forwarding source
//   ex_ctrl_t                   per-instruction control carried in the ID/EX register
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 5;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [ALU_OP_W-1:0]   alu_op_t;

  // The ALU decodes these same values, so they must not be renumbered here alone.
  localparam alu_op_t ALU_ADD  = 5'b00000;
  localparam alu_op_t ALU_SUB  = 5'b00001;
  localparam alu_op_t ALU_AND  = 5'b00010;
  localparam alu_op_t ALU_OR   = 5'b00011;
  localparam alu_op_t ALU_XOR  = 5'b00100;
  localparam alu_op_t ALU_SLL  = 5'b00101;
  localparam alu_op_t ALU_SRL  = 5'b00110;
  localparam alu_op_t ALU_SRA  = 5'b00111;
  localparam alu_op_t ALU_SLT  = 5'b01000;
  localparam alu_op_t ALU_SLTU = 5'b01001;
  localparam alu_op_t ALU_PASS = 5'b01010;

  localparam reg_addr_t ZERO_REG = '0;

  // Control that travels with an instruction from ID into EX.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic op1_pc;   // ALU operand 1 is the instruction PC
    logic op2_imm;  // ALU operand 2 is the immediate
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_NONE = '0;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle between the ID/EX operand stage and its surroundings (ID, MEM, WB, ALU).
// Latency: n/a (wiring only).
// Backpressure: stall/flush arrive from the pipeline; load_use_stall goes back to ID.
//
// Modports:
//   master  the pipeline side: drives ID, producer and stall/flush; receives EX outputs
//   slave   the operand stage itself
interface id_ex_operand_stage_if;
  import riscv_pkg::*;

  // pipeline control
  logic      stall;
  logic      flush;

  // instruction from ID
  logic      id_valid;
  logic      id_reg_write;
  logic      id_mem_read;
  logic      id_mem_write;
  logic      id_op1_pc;
  logic      id_op2_imm;
  alu_op_t   id_alu_op;
  reg_addr_t id_rs1_addr;
  reg_addr_t id_rs2_addr;
  reg_addr_t id_rd_addr;
  xlen_t     id_rs1_data;
  xlen_t     id_rs2_data;
  xlen_t     id_imm;
  xlen_t     id_pc;

  // producers further down the pipe
  logic      mem_reg_write;
  reg_addr_t mem_rd_addr;
  xlen_t     mem_result;
  logic      wb_reg_write;
  reg_addr_t wb_rd_addr;
  xlen_t     wb_result;

  // EX stage outputs
  xlen_t     DATA1;
  xlen_t     DATA2;
  alu_op_t   SELECT;
  logic      ex_valid;
  logic      ex_reg_write;
  logic      ex_mem_read;
  logic      ex_mem_write;
  reg_addr_t ex_rd_addr;
  xlen_t     ex_store_data;
  xlen_t     ex_pc;
  logic      load_use_stall;

  modport master (
    output stall, flush,
    output id_valid, id_reg_write, id_mem_read, id_mem_write, id_op1_pc, id_op2_imm,
    output id_alu_op, id_rs1_addr, id_rs2_addr, id_rd_addr,
    output id_rs1_data, id_rs2_data, id_imm, id_pc,
    output mem_reg_write, mem_rd_addr, mem_result,
    output wb_reg_write, wb_rd_addr, wb_result,
    input  DATA1, DATA2, SELECT,
    input  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd_addr,
    input  ex_store_data, ex_pc, load_use_stall
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_reg_write, id_mem_read, id_mem_write, id_op1_pc, id_op2_imm,
    input  id_alu_op, id_rs1_addr, id_rs2_addr, id_rd_addr,
    input  id_rs1_data, id_rs2_data, id_imm, id_pc,
    input  mem_reg_write, mem_rd_addr, mem_result,
    input  wb_reg_write, wb_rd_addr, wb_result,
    output DATA1, DATA2, SELECT,
    output ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd_addr,
    output ex_store_data, ex_pc, load_use_stall
  );

endinterface

// File: rtl/fwd_mux.sv
// One EX-stage forwarding selector: picks MEM result, WB result or the registered operand.
// Latency: zero cycles (purely combinational).
// Backpressure: none.
//
// Ports:
//   rs_addr, rs_data                         registered source index and value
//   mem_reg_write, mem_rd_addr, mem_result   producer in MEM (highest priority)
//   wb_reg_write, wb_rd_addr, wb_result      producer in WB
//   fwd_data                                 resolved operand
module fwd_mux
  import riscv_pkg::*;
(
  input  reg_addr_t rs_addr,
  input  xlen_t     rs_data,
  input  logic      mem_reg_write,
  input  reg_addr_t mem_rd_addr,
  input  xlen_t     mem_result,
  input  logic      wb_reg_write,
  input  reg_addr_t wb_rd_addr,
  input  xlen_t     wb_result,
  output xlen_t     fwd_data
);

  logic mem_hit;
  logic wb_hit;

  // x0 writes are architecturally discarded, so a producer targeting x0 never matches.
  // MEM holds the younger write, so it beats WB when both target the same register.
  always_comb begin
    mem_hit  = mem_reg_write && (mem_rd_addr != ZERO_REG) && (mem_rd_addr == rs_addr);
    wb_hit   = wb_reg_write  && (wb_rd_addr  != ZERO_REG) && (wb_rd_addr  == rs_addr);
    fwd_data = rs_data;
    if (mem_hit) begin
      fwd_data = mem_result;
    end else if (wb_hit) begin
      fwd_data = wb_result;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX operand forwarding, ALU operand muxing and load-use detection.
// Latency: 1 cycle ID->EX registers; forwarding and operand muxing are combinational.
// Backpressure: stall holds the stage, flush squashes it; load_use_stall holds ID and a bubble enters EX.
//
// Ports:
//   CLK, RESET_N   clock, synchronous active-low reset
//   bus (slave)    stall/flush, ID instruction fields, MEM/WB producers,
//                  ALU operands DATA1/DATA2/SELECT, EX control, store data, PC, load_use_stall
module id_ex_operand_stage
  import riscv_pkg::*;
(
  input logic                  CLK,
  input logic                  RESET_N,
  id_ex_operand_stage_if.slave bus
);

  // ID/EX register contents
  ex_ctrl_t  ctrl_q;
  alu_op_t   alu_op_q;
  reg_addr_t rd_addr_q;
  reg_addr_t rs1_addr_q;
  reg_addr_t rs2_addr_q;
  xlen_t     rs1_data_q;
  xlen_t     rs2_data_q;
  xlen_t     imm_q;
  xlen_t     pc_q;

  // combinational
  xlen_t     fwd_rs1;
  xlen_t     fwd_rs2;
  ex_ctrl_t  id_ctrl;
  logic      hazard;
  logic      load_use;
  logic      bubble;

  fwd_mux u_fwd_rs1 (
    .rs_addr       (rs1_addr_q),
    .rs_data       (rs1_data_q),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd_addr   (bus.mem_rd_addr),
    .mem_result    (bus.mem_result),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd_addr    (bus.wb_rd_addr),
    .wb_result     (bus.wb_result),
    .fwd_data      (fwd_rs1)
  );

  fwd_mux u_fwd_rs2 (
    .rs_addr       (rs2_addr_q),
    .rs_data       (rs2_data_q),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd_addr   (bus.mem_rd_addr),
    .mem_result    (bus.mem_result),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd_addr    (bus.wb_rd_addr),
    .wb_result     (bus.wb_result),
    .fwd_data      (fwd_rs2)
  );

  // A load in EX has no data until MEM, so an ID consumer of its rd must wait a cycle.
  // A flushed ID instruction is being discarded anyway, so it never requests a stall.
  always_comb begin
    hazard = ctrl_q.valid && ctrl_q.mem_read && (rd_addr_q != ZERO_REG) &&
             bus.id_valid &&
             ((rd_addr_q == bus.id_rs1_addr) || (rd_addr_q == bus.id_rs2_addr));
    load_use = RESET_N && !bus.flush && hazard;
    // A global stall keeps EX intact; the hazard is simply re-raised next cycle.
    bubble   = load_use && !bus.stall;
  end

  // An invalid ID slot enters EX with every control bit cleared.
  always_comb begin
    id_ctrl = EX_CTRL_NONE;
    if (bus.id_valid) begin
      id_ctrl.valid     = 1'b1;
      id_ctrl.reg_write = bus.id_reg_write;
      id_ctrl.mem_read  = bus.id_mem_read;
      id_ctrl.mem_write = bus.id_mem_write;
      id_ctrl.op1_pc    = bus.id_op1_pc;
      id_ctrl.op2_imm   = bus.id_op2_imm;
    end
  end

  // Precedence: reset, flush, stall, bubble, load.
  always_ff @(posedge CLK) begin
    if (!RESET_N || bus.flush) begin
      ctrl_q     <= EX_CTRL_NONE;
      alu_op_q   <= ALU_ADD;
      rd_addr_q  <= ZERO_REG;
      rs1_addr_q <= ZERO_REG;
      rs2_addr_q <= ZERO_REG;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
    end else if (bus.stall) begin
      // Control and addresses hold. The operands re-capture their forwarded value so a
      // producer that retires from WB while we are held is not lost once WB moves on.
      rs1_data_q <= fwd_rs1;
      rs2_data_q <= fwd_rs2;
    end else if (bubble) begin
      ctrl_q     <= EX_CTRL_NONE;
      alu_op_q   <= ALU_ADD;
      rd_addr_q  <= ZERO_REG;
      rs1_addr_q <= ZERO_REG;
      rs2_addr_q <= ZERO_REG;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
    end else begin
      ctrl_q     <= id_ctrl;
      alu_op_q   <= bus.id_alu_op;
      rd_addr_q  <= bus.id_rd_addr;
      rs1_addr_q <= bus.id_rs1_addr;
      rs2_addr_q <= bus.id_rs2_addr;
      rs1_data_q <= bus.id_rs1_data;
      rs2_data_q <= bus.id_rs2_data;
      imm_q      <= bus.id_imm;
      pc_q       <= bus.id_pc;
    end
  end

  // ALU operands: PC/immediate selection happens after forwarding.
  assign bus.DATA1          = ctrl_q.op1_pc  ? pc_q  : fwd_rs1;
  assign bus.DATA2          = ctrl_q.op2_imm ? imm_q : fwd_rs2;
  assign bus.SELECT         = alu_op_q;
  // Stores always need rs2, independent of the immediate mux.
  assign bus.ex_store_data  = fwd_rs2;

  assign bus.ex_valid       = ctrl_q.valid;
  assign bus.ex_reg_write   = ctrl_q.reg_write;
  assign bus.ex_mem_read    = ctrl_q.mem_read;
  assign bus.ex_mem_write   = ctrl_q.mem_write;
  assign bus.ex_rd_addr     = rd_addr_q;
  assign bus.ex_pc          = pc_q;
  assign bus.load_use_stall = load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: forwarding vector table, hand-written
// hazard/stall/flush/reset sequences, then randomized traffic against a reference model.
module tb_id_ex_operand_stage;
  import riscv_pkg::*;

  logic CLK = 1'b0;
  logic RESET_N;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK = ~CLK;

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.flush = 0;
    bus.id_valid = 0; bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.id_op1_pc = 0; bus.id_op2_imm = 0; bus.id_alu_op = ALU_ADD;
    bus.id_rs1_addr = 0; bus.id_rs2_addr = 0; bus.id_rd_addr = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_pc = 0;
    bus.mem_reg_write = 0; bus.mem_rd_addr = 0; bus.mem_result = 0;
    bus.wb_reg_write = 0; bus.wb_rd_addr = 0; bus.wb_result = 0;
  endtask

  // valid, reg-writing instruction in ID
  task automatic drive_id(input logic memr, input logic memw, input logic p1, input logic i2,
                          input logic [4:0] alu, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [31:0] pc);
    bus.id_valid = 1; bus.id_reg_write = 1; bus.id_mem_read = memr; bus.id_mem_write = memw;
    bus.id_op1_pc = p1; bus.id_op2_imm = i2; bus.id_alu_op = alu;
    bus.id_rs1_addr = rs1; bus.id_rs2_addr = rs2; bus.id_rd_addr = rd;
    bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm; bus.id_pc = pc;
  endtask

  // Cleared stage with no producers active: everything zero, opcode ADD.
  task automatic chk_cleared(input string tag);
    chk({tag, " ex_valid"},      32'(bus.ex_valid),      32'd0);
    chk({tag, " ex_reg_write"},  32'(bus.ex_reg_write),  32'd0);
    chk({tag, " ex_mem_read"},   32'(bus.ex_mem_read),   32'd0);
    chk({tag, " ex_mem_write"},  32'(bus.ex_mem_write),  32'd0);
    chk({tag, " SELECT"},        32'(bus.SELECT),        32'(ALU_ADD));
    chk({tag, " ex_rd_addr"},    32'(bus.ex_rd_addr),    32'd0);
    chk({tag, " ex_pc"},         bus.ex_pc,              32'd0);
    chk({tag, " DATA1"},         bus.DATA1,              32'd0);
    chk({tag, " DATA2"},         bus.DATA2,              32'd0);
    chk({tag, " ex_store_data"}, bus.ex_store_data,      32'd0);
  endtask

  // ---------------------------------------------------------------- forwarding table
  typedef struct {
    logic [4:0]  alu;
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2;
    logic        mrw;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        wrw;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic [31:0] e1, e2;
  } fwd_vec_t;

  fwd_vec_t vecs[8];

  // ---------------------------------------------------------------- reference model
  typedef struct {
    logic        v, rw, mr, mw, p1, i2;
    logic [4:0]  alu, rd, rs1, rs2;
    logic [31:0] d1, d2, imm, pc;
  } mdl_t;

  function automatic mdl_t empty_mdl();
    mdl_t e;
    e.v = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.p1 = 0; e.i2 = 0;
    e.alu = ALU_ADD; e.rd = 0; e.rs1 = 0; e.rs2 = 0;
    e.d1 = 0; e.d2 = 0; e.imm = 0; e.pc = 0;
    return e;
  endfunction

  // Newest architectural value of register a as seen by EX.
  function automatic logic [31:0] ref_value(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return d;
    if (bus.mem_reg_write && bus.mem_rd_addr == a) return bus.mem_result;
    if (bus.wb_reg_write && bus.wb_rd_addr == a) return bus.wb_result;
    return d;
  endfunction

  mdl_t m;

  // ---------------------------------------------------------------- test
  initial begin
    logic [31:0] f1, f2;
    logic        lus_m;
    mdl_t        cap;

    vecs[0] = '{alu:ALU_ADD, rs1:5, rs2:5, d1:0,      d2:0,      mrw:1, mrd:5, mres:7,        wrw:0, wrd:0,  wres:0,        e1:7,        e2:7};
    vecs[1] = '{alu:ALU_ADD, rs1:5, rs2:5, d1:0,      d2:0,      mrw:0, mrd:0, mres:0,        wrw:1, wrd:5,  wres:7,        e1:7,        e2:7};
    vecs[2] = '{alu:ALU_ADD, rs1:0, rs2:0, d1:0,      d2:0,      mrw:1, mrd:0, mres:32'hDEAD, wrw:0, wrd:0,  wres:0,        e1:0,        e2:0};
    vecs[3] = '{alu:ALU_SUB, rs1:3, rs2:4, d1:'h111,  d2:'h222,  mrw:1, mrd:3, mres:'hAAAA,   wrw:1, wrd:3,  wres:'hBBBB,   e1:'hAAAA,   e2:'h222};
    vecs[4] = '{alu:ALU_XOR, rs1:5, rs2:4, d1:'h10,   d2:'h20,   mrw:1, mrd:3, mres:'hAAAA,   wrw:1, wrd:4,  wres:'hCCCC,   e1:'h10,     e2:'hCCCC};
    vecs[5] = '{alu:ALU_OR,  rs1:5, rs2:6, d1:'h42,   d2:'h43,   mrw:0, mrd:5, mres:'hFFFF,   wrw:0, wrd:6,  wres:'hEEEE,   e1:'h42,     e2:'h43};
    vecs[6] = '{alu:ALU_AND, rs1:0, rs2:7, d1:0,      d2:'h70,   mrw:0, mrd:0, mres:0,        wrw:1, wrd:0,  wres:'h77,     e1:0,        e2:'h70};
    vecs[7] = '{alu:ALU_SLT, rs1:9, rs2:10, d1:'h9,   d2:'hA,    mrw:1, mrd:11, mres:'h1111,  wrw:1, wrd:12, wres:'h2222,   e1:'h9,      e2:'hA};

    // --- reset state
    idle();
    RESET_N = 0;
    tick(); tick();
    chk_cleared("reset");
    chk("reset load_use_stall", 32'(bus.load_use_stall), 32'd0);
    RESET_N = 1;

    // --- forwarding table
    for (int k = 0; k < 8; k++) begin
      idle();
      drive_id(0, 0, 0, 0, vecs[k].alu, vecs[k].rs1, vecs[k].rs2, 5'd6,
               vecs[k].d1, vecs[k].d2, 32'h0, 32'h200 + 32'(k) * 4);
      tick();
      idle();
      bus.mem_reg_write = vecs[k].mrw; bus.mem_rd_addr = vecs[k].mrd; bus.mem_result = vecs[k].mres;
      bus.wb_reg_write  = vecs[k].wrw; bus.wb_rd_addr  = vecs[k].wrd; bus.wb_result  = vecs[k].wres;
      settle();
      chk($sformatf("vec%0d DATA1", k),      bus.DATA1,         vecs[k].e1);
      chk($sformatf("vec%0d DATA2", k),      bus.DATA2,         vecs[k].e2);
      chk($sformatf("vec%0d store", k),      bus.ex_store_data, vecs[k].e2);
      chk($sformatf("vec%0d SELECT", k),     32'(bus.SELECT),   32'(vecs[k].alu));
      chk($sformatf("vec%0d ex_valid", k),   32'(bus.ex_valid), 32'd1);
    end

    // --- load-use: LW x7,16(x2) then ADD x8,x7,x1
    idle();
    drive_id(1, 0, 0, 1, ALU_ADD, 5'd2, 5'd0, 5'd7, 32'h1000, 32'h0, 32'h10, 32'h100);
    tick();
    chk("lw DATA1", bus.DATA1, 32'h1000);
    chk("lw DATA2 imm", bus.DATA2, 32'h10);
    chk("lw ex_mem_read", 32'(bus.ex_mem_read), 32'd1);
    drive_id(0, 0, 0, 0, ALU_ADD, 5'd7, 5'd1, 5'd8, 32'h0, 32'h5, 32'h0, 32'h104);
    settle();
    chk("lu stall raised", 32'(bus.load_use_stall), 32'd1);
    tick();
    bus.mem_reg_write = 1; bus.mem_rd_addr = 7; bus.mem_result = 32'hCAFE;
    settle();
    chk("lu bubble ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("lu stall one cycle", 32'(bus.load_use_stall), 32'd0);
    tick();
    settle();
    chk("lu add ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("lu add DATA1 fwd", bus.DATA1, 32'hCAFE);
    chk("lu add DATA2", bus.DATA2, 32'h5);
    chk("lu add ex_pc", bus.ex_pc, 32'h104);
    chk("lu add no stall", 32'(bus.load_use_stall), 32'd0);

    // --- op1 = PC path
    idle();
    drive_id(0, 0, 1, 1, ALU_ADD, 5'd3, 5'd0, 5'd4, 32'h33, 32'h0, 32'h800, 32'h4000);
    tick();
    idle();
    bus.mem_reg_write = 1; bus.mem_rd_addr = 3; bus.mem_result = 32'h9999;
    settle();
    chk("auipc DATA1 pc", bus.DATA1, 32'h4000);
    chk("auipc DATA2 imm", bus.DATA2, 32'h800);

    // --- stall across WB retire
    idle();
    drive_id(0, 0, 0, 0, ALU_OR, 5'd9, 5'd0, 5'd10, 32'h11, 32'h0, 32'h0, 32'h300);
    tick();
    idle();
    bus.stall = 1; bus.wb_reg_write = 1; bus.wb_rd_addr = 9; bus.wb_result = 32'h55;
    settle();
    chk("hold wb fwd", bus.DATA1, 32'h55);
    tick();
    bus.wb_rd_addr = 3; bus.wb_result = 32'h99;
    settle();
    chk("hold after wb moved", bus.DATA1, 32'h55);
    tick();
    bus.wb_reg_write = 0;
    tick();
    bus.stall = 0;
    settle();
    chk("hold release DATA1", bus.DATA1, 32'h55);
    chk("hold release ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("hold release SELECT", 32'(bus.SELECT), 32'(ALU_OR));
    chk("hold release rd", 32'(bus.ex_rd_addr), 32'd10);

    // --- stall and load-use together: hold wins, hazard persists
    idle();
    drive_id(1, 0, 0, 1, ALU_ADD, 5'd2, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 32'h500);
    tick();
    drive_id(0, 0, 0, 0, ALU_ADD, 5'd1, 5'd7, 5'd8, 32'h0, 32'h0, 32'h0, 32'h504);
    bus.stall = 1;
    settle();
    chk("stall+lu raised", 32'(bus.load_use_stall), 32'd1);
    tick();
    chk("stall+lu held valid", 32'(bus.ex_valid), 32'd1);
    chk("stall+lu held mem_read", 32'(bus.ex_mem_read), 32'd1);
    chk("stall+lu still raised", 32'(bus.load_use_stall), 32'd1);
    bus.stall = 0;
    tick();
    chk("stall+lu bubble", 32'(bus.ex_valid), 32'd0);

    // --- flush with stall
    idle();
    drive_id(1, 0, 0, 1, ALU_ADD, 5'd2, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 32'h600);
    tick();
    drive_id(0, 0, 0, 0, ALU_ADD, 5'd7, 5'd1, 5'd8, 32'h0, 32'h0, 32'h0, 32'h604);
    bus.flush = 1; bus.stall = 1;
    settle();
    chk("flush masks lu", 32'(bus.load_use_stall), 32'd0);
    tick();
    bus.flush = 0; bus.stall = 0;
    settle();
    chk("flush ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush lu after", 32'(bus.load_use_stall), 32'd0);
    chk("flush ex_mem_read", 32'(bus.ex_mem_read), 32'd0);

    // --- reset mid-stream
    idle();
    drive_id(1, 1, 1, 1, ALU_SUB, 5'd4, 5'd5, 5'd6, 32'hA, 32'hB, 32'hC, 32'h700);
    tick();
    chk("pre-reset ex_valid", 32'(bus.ex_valid), 32'd1);
    idle();
    RESET_N = 0;
    tick();
    chk_cleared("midreset");
    chk("midreset load_use_stall", 32'(bus.load_use_stall), 32'd0);
    RESET_N = 1;

    // --- randomized traffic against the model
    m = empty_mdl();
    for (int i = 0; i < 3000; i++) begin
      RESET_N           = (i == 0 || $urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      bus.stall         = ($urandom_range(0, 99) < 20);
      bus.flush         = ($urandom_range(0, 99) < 8);
      bus.id_valid      = ($urandom_range(0, 99) < 85);
      bus.id_reg_write  = 1'($urandom_range(0, 1));
      bus.id_mem_read   = ($urandom_range(0, 99) < 35);
      bus.id_mem_write  = 1'($urandom_range(0, 1));
      bus.id_op1_pc     = ($urandom_range(0, 99) < 20);
      bus.id_op2_imm    = ($urandom_range(0, 99) < 30);
      bus.id_alu_op     = 5'($urandom_range(0, 10));
      bus.id_rs1_addr   = 5'($urandom_range(0, 7));
      bus.id_rs2_addr   = 5'($urandom_range(0, 7));
      bus.id_rd_addr    = 5'($urandom_range(0, 7));
      bus.id_rs1_data   = $urandom;
      bus.id_rs2_data   = $urandom;
      bus.id_imm        = $urandom;
      bus.id_pc         = $urandom;
      bus.mem_reg_write = 1'($urandom_range(0, 1));
      bus.mem_rd_addr   = 5'($urandom_range(0, 7));
      bus.mem_result    = $urandom;
      bus.wb_reg_write  = 1'($urandom_range(0, 1));
      bus.wb_rd_addr    = 5'($urandom_range(0, 7));
      bus.wb_result     = $urandom;
      settle();

      f1 = ref_value(m.rs1, m.d1);
      f2 = ref_value(m.rs2, m.d2);
      lus_m = RESET_N && !bus.flush && m.v && m.mr && (m.rd != 5'd0) && bus.id_valid &&
              (m.rd == bus.id_rs1_addr || m.rd == bus.id_rs2_addr);

      if (i > 0) begin
        chk($sformatf("rnd%0d ex_valid", i),     32'(bus.ex_valid),       32'(m.v));
        chk($sformatf("rnd%0d ex_reg_write", i), 32'(bus.ex_reg_write),   32'(m.rw));
        chk($sformatf("rnd%0d ex_mem_read", i),  32'(bus.ex_mem_read),    32'(m.mr));
        chk($sformatf("rnd%0d ex_mem_write", i), 32'(bus.ex_mem_write),   32'(m.mw));
        chk($sformatf("rnd%0d ex_rd_addr", i),   32'(bus.ex_rd_addr),     32'(m.rd));
        chk($sformatf("rnd%0d ex_pc", i),        bus.ex_pc,               m.pc);
        chk($sformatf("rnd%0d load_use", i),     32'(bus.load_use_stall), 32'(lus_m));
        if (m.v) begin
          chk($sformatf("rnd%0d DATA1", i),  bus.DATA1,         m.p1 ? m.pc : f1);
          chk($sformatf("rnd%0d DATA2", i),  bus.DATA2,         m.i2 ? m.imm : f2);
          chk($sformatf("rnd%0d store", i),  bus.ex_store_data, f2);
          chk($sformatf("rnd%0d SELECT", i), 32'(bus.SELECT),   32'(m.alu));
        end
      end

      // advance the model by one edge
      if (!RESET_N || bus.flush) begin
        m = empty_mdl();
      end else if (bus.stall) begin
        m.d1 = f1;
        m.d2 = f2;
      end else if (lus_m) begin
        m = empty_mdl();
      end else begin
        cap     = empty_mdl();
        cap.v   = bus.id_valid;
        cap.rw  = bus.id_valid && bus.id_reg_write;
        cap.mr  = bus.id_valid && bus.id_mem_read;
        cap.mw  = bus.id_valid && bus.id_mem_write;
        cap.p1  = bus.id_valid && bus.id_op1_pc;
        cap.i2  = bus.id_valid && bus.id_op2_imm;
        cap.alu = bus.id_alu_op;
        cap.rd  = bus.id_rd_addr;
        cap.rs1 = bus.id_rs1_addr;
        cap.rs2 = bus.id_rs2_addr;
        cap.d1  = bus.id_rs1_data;
        cap.d2  = bus.id_rs2_data;
        cap.imm = bus.id_imm;
        cap.pc  = bus.id_pc;
        m = cap;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
